// File: rtl/aging_vector_sequencer.sv
// Aging/stress vector sequencer: replays stored vectors into a benchmark circuit,
// holds each one for a programmable settle time, and folds the responses into a signature.
module aging_vector_sequencer #(
    parameter int VEC_W = 207,
    parameter int OUT_W = 108,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [VEC_W-1:0] wr_data,
    input  logic             start,
    input  logic [AW:0]      num_vec,
    input  logic [3:0]       settle,
    input  logic             loop_en,
    input  logic             stop,
    output logic [VEC_W-1:0] dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    vec_idx,
    output logic [15:0]      pass_cnt,
    output logic             cap_valid,
    output logic [OUT_W-1:0] cap_data,
    output logic [OUT_W-1:0] signature
);
    localparam int DEPTH = 2**AW;

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [VEC_W-1:0]   r_mem [DEPTH];
    logic [VEC_W-1:0]   r_dut_in;
    logic [AW-1:0]      r_vec_idx;
    logic [15:0]        r_pass_cnt;
    logic [OUT_W-1:0]   r_sig;
    logic [AW:0]        r_num_vec;
    logic [3:0]         r_settle, r_cnt;
    logic               r_stop_req;
    logic               w_idle, w_busy, w_start_ok, w_last, w_stop_now;
    logic [AW:0]        w_nv_clamp;

    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_busy     = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CAPTURE);
    assign w_start_ok = w_idle && start;
    assign w_nv_clamp = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    assign w_last     = ({1'b0, r_vec_idx} == (r_num_vec - (AW+1)'(1)));
    // A stop seen any time during the run is held until the current capture retires.
    assign w_stop_now = stop || r_stop_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = (w_nv_clamp == '0) ? S_DONE : S_APPLY;
            S_APPLY:        w_next = (r_settle != 4'd0) ? S_SETTLE : S_CAPTURE;
            S_SETTLE:       if (r_cnt == 4'd1) w_next = S_CAPTURE;
            S_CAPTURE: begin
                if (w_stop_now)             w_next = S_DONE;
                else if (!w_last || loop_en) w_next = S_APPLY;
                else                        w_next = S_DONE;
            end
            default:        w_next = S_IDLE;
        endcase
    end

    // Vector store is deliberately not reset so patterns survive a run abort.
    always_ff @(posedge clk) begin
        if (wr_en && w_idle) r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dut_in   <= '0;
            r_vec_idx  <= '0;
            r_pass_cnt <= '0;
            r_sig      <= '0;
            r_num_vec  <= '0;
            r_settle   <= '0;
            r_cnt      <= '0;
            r_stop_req <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_sig      <= '0;
                r_pass_cnt <= '0;
                r_vec_idx  <= '0;
                r_num_vec  <= w_nv_clamp;
                r_settle   <= settle;
                r_stop_req <= 1'b0;
            end
            if (w_busy && stop) r_stop_req <= 1'b1;
            case (r_state)
                S_APPLY: begin
                    r_dut_in <= r_mem[r_vec_idx];
                    r_cnt    <= r_settle;
                end
                S_SETTLE: r_cnt <= r_cnt - 4'd1;
                S_CAPTURE: begin
                    r_sig <= {r_sig[OUT_W-2:0], r_sig[OUT_W-1]} ^ dut_out;
                    if (w_last && (r_pass_cnt != 16'hFFFF)) r_pass_cnt <= r_pass_cnt + 16'd1;
                    if (!w_stop_now) begin
                        if (!w_last)     r_vec_idx <= r_vec_idx + AW'(1);
                        else if (loop_en) r_vec_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = w_busy;
    assign done      = (r_state == S_DONE);
    assign vec_idx   = r_vec_idx;
    assign pass_cnt  = r_pass_cnt;
    assign cap_valid = (r_state == S_CAPTURE);
    assign cap_data  = cap_valid ? dut_out : '0;
    assign signature = r_sig;
endmodule

// File: doc/aging_vector_sequencer.md
AGING_VECTOR_SEQUENCER -- requirements
Module: aging_vector_sequencer

Interface
REQ-001 SHALL have parameter VEC_W, default 207, meaning DUT input vector width.
REQ-002 SHALL have parameter OUT_W, default 108, meaning DUT output vector width.
REQ-003 SHALL have parameter AW, default 5, meaning vector memory address width (DEPTH = 2**AW = 32).
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-006 SHALL have port wr_en, input, 1 bit, vector memory write strobe.
REQ-007 SHALL have port wr_addr, input, AW bits, vector memory write address.
REQ-008 SHALL have port wr_data, input, VEC_W bits, vector memory write data.
REQ-009 SHALL have port start, input, 1 bit, run request (level sampled per cycle).
REQ-010 SHALL have port num_vec, input, AW+1 bits, vectors per pass; sampled on accepted start.
REQ-011 SHALL have port settle, input, 4 bits, settle cycles per vector; sampled on accepted start.
REQ-012 SHALL have port loop_en, input, 1 bit, repeat passes until stop.
REQ-013 SHALL have port stop, input, 1 bit, end-of-run request.
REQ-014 SHALL have port dut_in, output, VEC_W bits, registered vector driven to the benchmark circuit.
REQ-015 SHALL have port dut_out, input, OUT_W bits, benchmark circuit response.
REQ-016 SHALL have ports busy (1), done (1), vec_idx (AW), pass_cnt (16), cap_valid (1), cap_data (OUT_W), signature (OUT_W), all outputs.

Function
REQ-017 SHALL implement FSM states IDLE, APPLY, SETTLE, CAPTURE, DONE.
REQ-018 SHALL write wr_data to mem[wr_addr] on wr_en only in IDLE or DONE; writes in other states are dropped.
REQ-019 SHALL accept start only in IDLE or DONE: clear signature, pass_cnt, vec_idx, done; latch num_vec (clamped to DEPTH if greater) and settle.
REQ-020 SHALL, on accepted start with num_vec = 0, go directly to DONE with no vector applied.
REQ-021 SHALL, in APPLY (1 cycle), register dut_in <= mem[vec_idx]; next state SETTLE if settle > 0, else CAPTURE.
REQ-022 SHALL stay in SETTLE exactly settle cycles, then go to CAPTURE.
REQ-023 SHALL, in CAPTURE (1 cycle), assert cap_valid, drive cap_data = dut_out, update signature <= {signature[OUT_W-2:0], signature[OUT_W-1]} ^ dut_out.
REQ-024 SHALL make per-vector latency 2 + settle cycles, from APPLY entry to CAPTURE exit.
REQ-025 SHALL, after CAPTURE with vec_idx < num_vec-1 and stop low, increment vec_idx and go to APPLY.
REQ-026 SHALL, after CAPTURE with vec_idx = num_vec-1, increment pass_cnt (saturating at 16'hFFFF); then if loop_en high and stop low, set vec_idx = 0 and go to APPLY, else go to DONE.
REQ-027 SHALL honour stop only at CAPTURE exit: the current vector completes its capture, then DONE.
REQ-028 SHALL assert busy in APPLY, SETTLE, CAPTURE; assert done in DONE; hold done until the next accepted start.
REQ-029 SHALL hold dut_in at its last applied value in SETTLE, CAPTURE, DONE and IDLE (static stress).
REQ-030 SHALL ignore start while busy; start and stop in the same CAPTURE exit cycle count as stop.

Reset
REQ-031 SHALL, on rst high, immediately enter IDLE and clear dut_in, vec_idx, pass_cnt, signature, cap_data, cap_valid, busy and done to 0, including mid-run.
REQ-032 SHALL NOT clear vector memory contents on reset.

Verification
REQ-033 SHALL cover load of mem[0..2] = 1, 2, 3; num_vec=3, settle=0, loop_en=0, start -> dut_in = 1, 2, 3 every 2 cycles; 3 cap_valid pulses; pass_cnt=1; done high.
REQ-034 SHALL cover settle=4 with dut_out tied to dut_in[OUT_W-1:0] -> cap_valid spacing of 6 cycles; signature equals the reference rotate-XOR of the three vectors.
REQ-035 SHALL cover loop_en=1, num_vec=2, stop pulsed during the 2nd vector of pass 3 -> that capture completes; pass_cnt=3; DONE; dut_in holds mem[1].
REQ-036 SHALL cover num_vec=0, start -> done high next cycle; no cap_valid; dut_in unchanged.
REQ-037 SHALL cover wr_en and start while busy -> memory unchanged and run unaffected; rst asserted mid-SETTLE -> all outputs 0 in the same cycle and IDLE.
REQ-038 SHALL cover num_vec=40 -> clamped to 32 captures per pass.
